cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Instruction-cycle controller for the 8-bit accumulator CPU. An 8-phase counter sequences every
//  instruction. Phase plus the IR opcode and the ALU zero flag decode into the strobes that drive
//  the address mux, memory, IR, PC, accumulator and data bus. Sits between the IR/ALU and the
//  register/memory datapath. Opcodes match the ALU encoding:
//  HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111.
// PARAMETERS
//  NPHASE   8   phases per instruction; fixed, width 3 (not overridable)
// PORTS
//  clk      in   1  system clock, rising edge
//  rst_     in   1  synchronous, active-low reset
//  opcode   in   3  IR[7:5]; sampled only in phases 4..7
//  zero     in   1  ALU zero flag (accumulator == 0)
//  phase    out  3  current phase counter
//  sel      out  1  address mux: 1 = PC, 0 = IR operand
//  rd       out  1  memory read enable
//  ld_ir    out  1  load instruction register
//  inc_pc   out  1  increment PC
//  ld_pc    out  1  load PC from IR operand
//  data_e   out  1  drive accumulator onto data bus
//  ld_ac    out  1  load accumulator from ALU out
//  wr       out  1  memory write strobe
//  halt     out  1  CPU halted; sticky until reset
// BEHAVIOUR
//  - Reset (rst_=0 at posedge): phase=0, halted=0.
//    Outputs then decode phase 0: sel=1, all other strobes 0, halt=0.
//    Reset mid-instruction aborts it; nothing is pending afterwards.
//  - Phase advances by 1 each clk and wraps 7->0. One instruction = 8 cycles.
//  - Strobes are combinational decode of registered phase/halted, opcode and zero.
//    ALUOP = ADD|AND|XOR|LDA.
//    0 INST_ADDR : sel
//    1 INST_FETCH: sel rd
//    2 INST_LOAD : sel rd ld_ir
//    3 IDLE      : sel rd ld_ir
//    4 OP_ADDR   : inc_pc (not HLT); halt (HLT)
//    5 OP_FETCH  : rd=ALUOP
//    6 ALU_OP    : rd=ALUOP; inc_pc=SKZ&zero; ld_pc=JMP; data_e=STO
//    7 STORE     : rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO
//  - HLT: in phase 4, halt=1 and inc_pc=0. At that posedge halted<=1 and phase stays at 4.
//    While halted: halt=1, all other strobes 0, phase frozen at 4. Only reset exits.
//  - SKZ with zero=0, and HLT, never assert rd in phases 5-7.
//  - wr is asserted only in phase 7 and only when data_e=1 (bus driven for the whole strobe).
//  - X or Z on opcode in phases 4-7: strobes follow the default (no ALUOP, no JMP/STO).
//    The bench flags this as an error.
// CONFIGURATION
//  SEQ_STEP_EN: adds input `step` (1 bit).
//    - Defined: phase 0 holds, with strobes decoded as phase 0, until a cycle where step=1.
//      That cycle advances to phase 1. Phases 1-7 ignore step. Reset also clears any pending step.
//    - Undefined: no step port; free-running sequencing.
// TESTING
//  1 Reset: rst_=0 for 2 clk, then 1 -> phase=0, sel=1, rd/ld_ir/inc_pc/ld_pc/data_e/ld_ac/wr/halt=0;
//    phase reaches 1 one cycle after release.
//  2 ADD (opcode=010) over 8 clk -> ld_ir=1 in phases 2,3; inc_pc=1 in phase 4;
//    rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; wr=0 throughout.
//  3 STO (110) -> data_e=1 in phases 6,7; wr=1 in phase 7 only; rd=0 in phases 5-7.
//  4 SKZ (001): zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 in phase 4 only.
//    JMP (111) -> ld_pc=1 in phases 6,7.
//  5 HLT (000) -> halt=1 from phase 4 on; phase stays 4 for 20 clk with all other strobes 0;
//    rst_=0 -> phase=0, halt=0.
//  6 Reset at phase 5 of LDA -> next cycle phase=0, rd=0, ld_ac never pulses.
//    Under SEQ_STEP_EN: step=0 for 5 clk holds phase 0; step=1 -> phase=1 next cycle.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase instruction-cycle controller for the accumulator CPU.
// Optional single-step gate at phase 0 when SEQ_STEP_EN is defined.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_,
`ifdef SEQ_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic       halt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  phase_t phase_q;
  phase_t phase_d;
  logic   halted_q;
  logic   halted_d;

  logic   is_hlt;
  logic   is_skz;
  logic   is_jmp;
  logic   is_sto;
  logic   aluop;
  logic   hold0;

  assign phase = phase_q;

  // Opcode class decode; unknown opcodes fall to the inert default.
  always_comb begin
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_jmp = 1'b0;
    is_sto = 1'b0;
    aluop  = 1'b0;
    case (opcode)
      OP_HLT: is_hlt = 1'b1;
      OP_SKZ: is_skz = 1'b1;
      OP_ADD: aluop  = 1'b1;
      OP_AND: aluop  = 1'b1;
      OP_XOR: aluop  = 1'b1;
      OP_LDA: aluop  = 1'b1;
      OP_STO: is_sto = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      default: ;
    endcase
  end

  // Phase-0 stall request from the single-step gate.
`ifdef SEQ_STEP_EN
  assign hold0 = (phase_q == INST_ADDR) && !step;
`else
  assign hold0 = 1'b0;
`endif

  // Phase and halted-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase: advance and wrap, freeze on halt or step stall.
  always_comb begin
    phase_d  = phase_t'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if (phase_q == OP_ADDR && is_hlt) begin
      phase_d  = OP_ADDR;
      halted_d = 1'b1;
    end else if (hold0) begin
      phase_d = INST_ADDR;
    end
  end

  // Strobe decode from registered phase/halted plus opcode and zero.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = is_hlt;
          inc_pc = !is_hlt;
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
        default: ;
      endcase
    end
  end

endmodule
